// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the half-integer clock-divider controller.
//   CW_DEF   : default width of the period counter (cfg_half is CW+1 bits)
//   MIN_HALF : smallest legal ratio x2 (ratio 2.0)
//   state_e  : controller FSM states
//   phase_e  : long (A) / short (B) period of an odd ratio x2
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int CW_DEF   = 8;
    localparam int MIN_HALF = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic {
        PH_A,
        PH_B
    } phase_e;

endpackage

// File: rtl/div_period_gen.sv
// -----------------------------------------------------------------------------
// div_period_gen
// Period counter for one output period of length len_i, producing the
// registered period-start tick and divided clock level aligned with the count.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   run_i     in   count enable; low forces count 0 with both outputs low
//   start_i   in   begin a fresh period on the next cycle
//   len_i     in   length P of the period the current count belongs to
//   tick_o    out  high while count == 0
//   clk_div_o out  high while count < P>>1
//   last_o    out  current cycle is the final cycle (count == P-1)
// -----------------------------------------------------------------------------
module div_period_gen
    import div_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_i,
    input  logic        start_i,
    input  logic [CW:0] len_i,
    output logic        tick_o,
    output logic        clk_div_o,
    output logic        last_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          div_q, div_d;

    assign last_o    = ({1'b0, cnt_q} == (len_i - (CW+1)'(1)));
    assign tick_o    = tick_q;
    assign clk_div_o = div_q;

    // len_i only changes at a wrap, and a wrap always lands on count 0 where
    // clk_div is high for every legal length (P >= 2), so the current length
    // is the right one to judge the next count against.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        div_d  = ({1'b0, cnt_d} < (len_i >> 1));
        if (!run_i) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            div_d  = 1'b0;
        end else if (start_i || last_o) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
// Programmable half-integer clock-divider controller. The ratio is cur_half/2;
// odd cur_half alternates a long period A (L+1) and short period B (L), with
// L = cur_half>>1. New ratios arrive through a valid/ready handshake and take
// effect only at a period boundary that leads into phase A, or on stopping.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   en         in   run enable
//   cfg_valid  in   new ratio offered
//   cfg_ready  out  no ratio is pending
//   cfg_half   in   requested ratio x2 (legal: >= MIN_HALF)
//   cfg_err    out  one-cycle pulse after an illegal ratio is accepted
//   cur_half   out  ratio x2 in effect
//   busy       out  FSM in RUN
//   tick       out  cycle 0 of every output period
//   clk_div    out  divided clock level
// -----------------------------------------------------------------------------
module div_sched
    import div_pkg::*;
#(
    parameter int CW           = CW_DEF,
    parameter int DEFAULT_HALF = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [CW:0] cfg_half,
    output logic        cfg_err,
    output logic [CW:0] cur_half,
    output logic        busy,
    output logic        tick,
    output logic        clk_div
);

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [CW:0] cur_half_q, cur_half_d;
    logic [CW:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        cfg_err_q, cfg_err_d;

    logic        odd;
    logic [CW:0] half_len;
    logic [CW:0] per_len;
    logic        last;
    logic        running;
    logic        bnd_a;
    logic        xfer;
    logic        illegal;

    assign odd      = cur_half_q[0];
    assign half_len = cur_half_q >> 1;
    assign per_len  = (odd && (phase_q == PH_A)) ? half_len + (CW+1)'(1) : half_len;

    assign running  = (state_q == RUN) && en;
    // Boundary whose following period is phase A: any period end for an even
    // ratio, only the end of period B for an odd one.
    assign bnd_a    = running && last && (!odd || (phase_q == PH_B));

    assign xfer     = cfg_valid && !pend_vld_q;
    assign illegal  = (cfg_half < (CW+1)'(MIN_HALF));

    assign cfg_ready = !pend_vld_q;
    assign cfg_err   = cfg_err_q;
    assign cur_half  = cur_half_q;
    assign busy      = (state_q == RUN);

    div_period_gen #(
        .CW(CW)
    ) u_period (
        .clk       (clk),
        .rst       (rst),
        .run_i     (en),
        .start_i   (state_q == IDLE),
        .len_i     (per_len),
        .tick_o    (tick),
        .clk_div_o (clk_div),
        .last_o    (last)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = PH_A;
        cur_half_d = cur_half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (running) begin
            if (!last) begin
                phase_d = phase_q;
            end else if (odd && (phase_q == PH_A)) begin
                phase_d = PH_B;
            end
        end

        // While running the value has to wait for a safe boundary; otherwise
        // (idle, or stopping this cycle) it can take effect straight away.
        if (xfer) begin
            if (illegal) begin
                cfg_err_d = 1'b1;
            end else if (running) begin
                pend_d     = cfg_half;
                pend_vld_d = 1'b1;
            end else begin
                cur_half_d = cfg_half;
            end
        end

        if (pend_vld_q && (bnd_a || ((state_q == RUN) && !en))) begin
            cur_half_d = pend_q;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_A;
            cur_half_q <= (CW+1)'(DEFAULT_HALF);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cur_half_q <= cur_half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;

    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [CW:0] cfg_half;
    logic        cfg_err;
    logic [CW:0] cur_half;
    logic        busy;
    logic        tick;
    logic        clk_div;

    typedef struct {
        string       tag;
        logic        tick;
        logic        clk_div;
        logic        busy;
        logic        cfg_ready;
        logic        cfg_err;
        logic [CW:0] cur_half;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_sched #(
        .CW           (CW),
        .DEFAULT_HALF (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_err   (cfg_err),
        .cur_half  (cur_half),
        .busy      (busy),
        .tick      (tick),
        .clk_div   (clk_div)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic t, input logic d, input logic b,
                        input logic r, input logic e, input logic [CW:0] h);
        exp_t x;
        x.tag = tag; x.tick = t; x.clk_div = d; x.busy = b;
        x.cfg_ready = r; x.cfg_err = e; x.cur_half = h;
        sb.push_back(x);
    endtask

    // Expected cycles c0..c1 of a running period of length p.
    task automatic push_run(input string tag, input int p, input int c0, input int c1,
                            input logic [CW:0] h, input logic r);
        for (int c = c0; c <= c1; c++)
            push(tag, (c == 0), (c < p / 2), 1'b1, r, 1'b0, h);
    endtask

    task automatic push_idle(input string tag, input int n, input logic [CW:0] h, input logic e);
        for (int i = 0; i < n; i++)
            push(tag, 1'b0, 1'b0, 1'b0, 1'b1, e, h);
    endtask

    task automatic check_one();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow: observed output cycle with no expectation queued, required one");
        end else begin
            x = sb.pop_front();
            assert ({tick, clk_div, busy, cfg_ready, cfg_err, cur_half} ===
                    {x.tick, x.clk_div, x.busy, x.cfg_ready, x.cfg_err, x.cur_half})
            else begin
                errors++;
                $error("FAIL %s: observed tick=%b clk_div=%b busy=%b cfg_ready=%b cfg_err=%b cur_half=%0d required tick=%b clk_div=%b busy=%b cfg_ready=%b cfg_err=%b cur_half=%0d",
                       x.tag, tick, clk_div, busy, cfg_ready, cfg_err, cur_half,
                       x.tick, x.clk_div, x.busy, x.cfg_ready, x.cfg_err, x.cur_half);
            end
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_one();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;

        // Reset values
        push_idle("reset", 1, 11, 1'b0);
        advance(1);
        rst = 1'b0;

        // Illegal ratio in IDLE: one-cycle error, ratio unchanged
        cfg_valid = 1'b1; cfg_half = 3;
        push_idle("illegal_err", 1, 11, 1'b1);
        advance(1);
        cfg_valid = 1'b0;
        push_idle("illegal_clear", 2, 11, 1'b0);
        advance(2);

        // Default ratio 5.5: periods 6,5,6,5
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_run("r11_A", 6, 0, 5, 11, 1'b1);
            push_run("r11_B", 5, 0, 4, 11, 1'b1);
        end
        advance(22);

        // Stop at cnt=2 of period A, then restart with a full period A
        push_run("r11_A_prestop", 6, 0, 2, 11, 1'b1);
        advance(3);
        en = 1'b0;
        push_idle("stopped", 2, 11, 1'b0);
        advance(2);
        en = 1'b1;
        push_run("restart_A", 6, 0, 5, 11, 1'b1);
        push_run("restart_B", 5, 0, 4, 11, 1'b1);
        advance(11);

        // Ratio 3.5 offered in period A; held until end of period B
        push_run("r11_A", 6, 0, 0, 11, 1'b1);
        advance(1);
        cfg_valid = 1'b1; cfg_half = 7;
        push_run("pend7_A", 6, 1, 1, 11, 1'b0);
        advance(1);
        cfg_valid = 1'b0;
        push_run("pend7_A", 6, 2, 5, 11, 1'b0);
        push_run("pend7_B", 5, 0, 4, 11, 1'b0);
        advance(9);
        for (int k = 0; k < 2; k++) begin
            push_run("r7_A", 4, 0, 3, 7, 1'b1);
            push_run("r7_B", 3, 0, 2, 7, 1'b1);
        end
        advance(14);

        // Back to IDLE, then ratio 4 applied immediately
        en = 1'b0;
        push_idle("idle7", 2, 7, 1'b0);
        advance(2);
        cfg_valid = 1'b1; cfg_half = 8;
        push_idle("idle_cfg8", 1, 8, 1'b0);
        advance(1);
        cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 3; k++)
            push_run("r8", 4, 0, 3, 8, 1'b1);
        advance(12);

        // Even ratio: pending value applied at the end of the current period
        push_run("r8", 4, 0, 0, 8, 1'b1);
        advance(1);
        cfg_valid = 1'b1; cfg_half = 12;
        push_run("pend12", 4, 1, 1, 8, 1'b0);
        advance(1);
        cfg_valid = 1'b0;
        push_run("pend12", 4, 2, 3, 8, 1'b0);
        advance(2);
        for (int k = 0; k < 2; k++)
            push_run("r12", 6, 0, 5, 12, 1'b1);
        advance(12);

        // en falls while a value is pending: applied on entry to IDLE
        push_run("r12", 6, 0, 0, 12, 1'b1);
        advance(1);
        cfg_valid = 1'b1; cfg_half = 10;
        push_run("pend10", 6, 1, 1, 12, 1'b0);
        advance(1);
        cfg_valid = 1'b0; en = 1'b0;
        push_idle("stop_apply10", 2, 10, 1'b0);
        advance(2);

        // Transfer on a boundary waits; reset then discards the pending value
        en = 1'b1;
        push_run("r10", 5, 0, 4, 10, 1'b1);
        advance(5);
        cfg_valid = 1'b1; cfg_half = 9;
        push_run("pend9", 5, 0, 0, 10, 1'b0);
        advance(1);
        cfg_valid = 1'b0;
        push_run("pend9", 5, 1, 1, 10, 1'b0);
        advance(1);
        rst = 1'b1; en = 1'b0;
        push_idle("rst_mid", 1, 11, 1'b0);
        advance(1);
        rst = 1'b0;
        push_idle("after_rst", 3, 11, 1'b0);
        advance(3);
        en = 1'b1;
        push_run("post_rst_A", 6, 0, 5, 11, 1'b1);
        push_run("post_rst_B", 5, 0, 4, 11, 1'b1);
        advance(11);

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain: observed %0d leftover expectations, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
